// File: rtl/vga_timing_driver.sv
// 640x480@60 VGA timing: free-running h/v counters decoded into syncs, pixel requests and blanked RGB.
// Request-to-RGB latency is one cycle (absorbs the generator's output register); no backpressure.
module vga_timing_driver #(
  parameter int H_SYNC  = 96,
  parameter int H_BACK  = 48,
  parameter int H_DISP  = 640,
  parameter int H_FRONT = 16,
  parameter int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 33,
  parameter int V_DISP  = 480,
  parameter int V_FRONT = 10,
  parameter int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic [15:0] pixel_data,
  output logic [9:0]  pixel_xpos,
  output logic [9:0]  pixel_ypos,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic [15:0] vga_rgb,
  output logic        frame_start
);

  localparam logic [9:0] LP_H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] LP_V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] LP_H_SYNC    = 10'(H_SYNC);
  localparam logic [9:0] LP_V_SYNC    = 10'(V_SYNC);
  localparam logic [9:0] LP_HA        = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] LP_HA_END    = 10'(H_SYNC + H_BACK + H_DISP);
  localparam logic [9:0] LP_HREQ      = 10'(H_SYNC + H_BACK - 1);
  localparam logic [9:0] LP_HREQ_END  = 10'(H_SYNC + H_BACK + H_DISP - 1);
  localparam logic [9:0] LP_VA        = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] LP_VA_END    = 10'(V_SYNC + V_BACK + V_DISP);

  logic [9:0] r_cnt_h;
  logic [9:0] r_cnt_v;
  logic       r_frame_start;

  logic       w_h_last;
  logic       w_v_last;
  logic       w_v_act;
  logic       w_vga_en;
  logic       w_data_req;

  assign w_h_last = (r_cnt_h == LP_H_LAST);
  assign w_v_last = (r_cnt_v == LP_V_LAST);

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cnt_h       <= '0;
      r_cnt_v       <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_cnt_h <= w_h_last ? '0 : r_cnt_h + 10'd1;
      if (w_h_last) begin
        r_cnt_v <= w_v_last ? '0 : r_cnt_v + 10'd1;
      end
      // Only a wrap out of the last pixel of a frame pulses, so the frame after reset is silent.
      r_frame_start <= w_h_last && w_v_last;
    end
  end

  assign w_v_act    = (r_cnt_v >= LP_VA) && (r_cnt_v < LP_VA_END);
  assign w_vga_en   = w_v_act && (r_cnt_h >= LP_HA) && (r_cnt_h < LP_HA_END);
  // Requests lead the display window by one cycle to cover the generator's register.
  assign w_data_req = w_v_act && (r_cnt_h >= LP_HREQ) && (r_cnt_h < LP_HREQ_END);

  assign vga_hs      = (r_cnt_h >= LP_H_SYNC);
  assign vga_vs      = (r_cnt_v >= LP_V_SYNC);
  assign pixel_xpos  = w_data_req ? (r_cnt_h - LP_HREQ) : '0;
  assign pixel_ypos  = w_data_req ? (r_cnt_v - LP_VA) : '0;
  assign vga_rgb     = w_vga_en ? pixel_data : 16'h0000;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_driver.sv
// Bench for vga_timing_driver using a shrunken raster so several full frames fit in a short run.
module tb_vga_timing_driver;

  localparam int HS = 6, HB = 4, HD = 16, HF = 3, HT = HS + HB + HD + HF;
  localparam int VS = 2, VB = 3, VD = 6, VF = 2, VT = VS + VB + VD + VF;
  localparam int FT = HT * VT;
  localparam int HA = HS + HB;
  localparam int VA = VS + VB;

  logic        vga_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [15:0] pixel_data = 16'h0000;
  logic [9:0]  pixel_xpos;
  logic [9:0]  pixel_ypos;
  logic        vga_hs;
  logic        vga_vs;
  logic [15:0] vga_rgb;
  logic        frame_start;

  int          total = 0;
  int          bad = 0;
  int          t = 0;
  bit          running = 1'b0;
  logic [15:0] salt = 16'h1234;
  logic [15:0] blank = 16'hFFFF;

  vga_timing_driver #(
    .H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF), .H_TOTAL(HT),
    .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF), .V_TOTAL(VT)
  ) dut (
    .vga_clk(vga_clk),
    .sys_rst_n(sys_rst_n),
    .pixel_data(pixel_data),
    .pixel_xpos(pixel_xpos),
    .pixel_ypos(pixel_ypos),
    .vga_hs(vga_hs),
    .vga_vs(vga_vs),
    .vga_rgb(vga_rgb),
    .frame_start(frame_start)
  );

  always #5 vga_clk = ~vga_clk;

  // Reference raster: position derived from absolute cycles since reset release.
  function automatic int mh(int tt); return tt % HT; endfunction
  function automatic int mv(int tt); return (tt / HT) % VT; endfunction
  function automatic bit m_vact(int tt); return mv(tt) >= VA && mv(tt) < VA + VD; endfunction
  function automatic bit m_en(int tt); return m_vact(tt) && mh(tt) >= HA && mh(tt) < HA + HD; endfunction
  function automatic bit m_req(int tt); return m_vact(tt) && mh(tt) >= HA - 1 && mh(tt) < HA + HD - 1; endfunction
  function automatic int m_x(int tt); return m_req(tt) ? mh(tt) - (HA - 1) : 0; endfunction
  function automatic int m_y(int tt); return m_req(tt) ? mv(tt) - VA : 0; endfunction
  function automatic bit m_hs(int tt); return mh(tt) >= HS; endfunction
  function automatic bit m_vs(int tt); return mv(tt) >= VS; endfunction
  function automatic bit m_fs(int tt); return tt > 0 && (tt % FT) == 0; endfunction

  function automatic logic [15:0] pix(int x, int y);
    return 16'((x * 37) ^ (y << 10)) ^ salt;
  endfunction

  function automatic logic [15:0] m_rgb(int tt);
    return m_en(tt) ? pix(mh(tt) - HA, mv(tt) - VA) : 16'h0000;
  endfunction

  // One clock; emulates the registered pattern generator answering last cycle's request.
  task automatic tick();
    logic [9:0] cx, cy;
    bit cr;
    cx = pixel_xpos;
    cy = pixel_ypos;
    cr = running && m_req(t);
    @(posedge vga_clk);
    if (running) t++;
    #1 pixel_data = cr ? pix(int'(cx), int'(cy)) : blank;
    #1;
  endtask

  task automatic run_to(int target);
    while (t < target) tick();
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    running = 1'b0;
    t = 0;
    repeat (10) begin
      tick();
      total++; if (vga_hs !== 1'b0) begin bad++; $display("FAIL rst_hs: got %b want 0", vga_hs); end
      total++; if (vga_vs !== 1'b0) begin bad++; $display("FAIL rst_vs: got %b want 0", vga_vs); end
      total++; if (vga_rgb !== 16'h0) begin bad++; $display("FAIL rst_rgb: got %h want 0", vga_rgb); end
      total++; if (pixel_xpos !== 10'd0) begin bad++; $display("FAIL rst_xpos: got %0d want 0", pixel_xpos); end
      total++; if (pixel_ypos !== 10'd0) begin bad++; $display("FAIL rst_ypos: got %0d want 0", pixel_ypos); end
      total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL rst_fs: got %b want 0", frame_start); end
    end
    sys_rst_n = 1'b1;
    running = 1'b1;
    begin
      int n;
      n = 0;
      while (vga_hs !== 1'b1 && n < 1000) begin
        tick();
        n++;
      end
      total++; if (n != HS) begin bad++; $display("FAIL hs_rise: got %0d cycles want %0d", n, HS); end
    end
  endtask

  task automatic test_horizontal();
    int falls, last_fall, low_len;
    logic prev_hs;
    falls = 0; last_fall = -1; low_len = 0;
    prev_hs = vga_hs;
    repeat (3 * HT) begin
      tick();
      total++; if (vga_hs !== m_hs(t)) begin bad++; $display("FAIL h_hs t=%0d: got %b want %b", t, vga_hs, m_hs(t)); end
      total++; if (pixel_xpos !== 10'(m_x(t))) begin bad++; $display("FAIL h_xpos t=%0d: got %0d want %0d", t, pixel_xpos, m_x(t)); end
      if (vga_hs === 1'b0) low_len++;
      if (prev_hs === 1'b1 && vga_hs === 1'b0) begin
        if (last_fall >= 0) begin
          total++; if (t - last_fall != HT) begin bad++; $display("FAIL hs_period: got %0d want %0d", t - last_fall, HT); end
        end
        last_fall = t;
        falls++;
        low_len = 1;
      end
      if (prev_hs === 1'b0 && vga_hs === 1'b1 && last_fall >= 0) begin
        total++; if (low_len != HS) begin bad++; $display("FAIL hs_width: got %0d want %0d", low_len, HS); end
      end
      prev_hs = vga_hs;
    end
    total++; if (falls != 3) begin bad++; $display("FAIL hs_falls: got %0d want 3", falls); end
  endtask

  task automatic test_frame();
    int vs_low, fs_cnt;
    vs_low = 0; fs_cnt = 0;
    blank = 16'hFFFF;
    while (t < 3 * FT) begin
      tick();
      total++; if (vga_hs !== m_hs(t)) begin bad++; $display("FAIL f_hs t=%0d: got %b want %b", t, vga_hs, m_hs(t)); end
      total++; if (vga_vs !== m_vs(t)) begin bad++; $display("FAIL f_vs t=%0d: got %b want %b", t, vga_vs, m_vs(t)); end
      total++; if (pixel_xpos !== 10'(m_x(t))) begin bad++; $display("FAIL f_xpos t=%0d: got %0d want %0d", t, pixel_xpos, m_x(t)); end
      total++; if (pixel_ypos !== 10'(m_y(t))) begin bad++; $display("FAIL f_ypos t=%0d: got %0d want %0d", t, pixel_ypos, m_y(t)); end
      total++; if (vga_rgb !== m_rgb(t)) begin bad++; $display("FAIL f_rgb t=%0d: got %h want %h", t, vga_rgb, m_rgb(t)); end
      total++; if (frame_start !== m_fs(t)) begin bad++; $display("FAIL f_fs t=%0d: got %b want %b", t, frame_start, m_fs(t)); end
      if (t > FT && vga_vs === 1'b0) vs_low++;
      if (frame_start === 1'b1) fs_cnt++;
    end
    total++; if (vs_low != 2 * VS * HT) begin bad++; $display("FAIL vs_low: got %0d want %0d", vs_low, 2 * VS * HT); end
    total++; if (fs_cnt != 3) begin bad++; $display("FAIL fs_count: got %0d want 3", fs_cnt); end
  endtask

  task automatic test_corners();
    int base;
    base = ((t / FT) + 1) * FT;
    blank = 16'hFFFF;
    run_to(base + (VA - 1) * HT);
    repeat (HT) begin
      total++; if (pixel_xpos !== 10'd0 || pixel_ypos !== 10'd0 || vga_rgb !== 16'h0)
        begin bad++; $display("FAIL pre_line h=%0d: got x=%0d y=%0d rgb=%h want 0", mh(t), pixel_xpos, pixel_ypos, vga_rgb); end
      tick();
    end
    run_to(base + VA * HT + HA - 1);
    total++; if (pixel_xpos !== 10'd0) begin bad++; $display("FAIL first_x: got %0d want 0", pixel_xpos); end
    total++; if (pixel_ypos !== 10'd0) begin bad++; $display("FAIL first_y: got %0d want 0", pixel_ypos); end
    total++; if (vga_rgb !== 16'h0) begin bad++; $display("FAIL first_rgb: got %h want 0", vga_rgb); end
    tick();
    total++; if (vga_rgb !== pix(0, 0)) begin bad++; $display("FAIL first_pix: got %h want %h", vga_rgb, pix(0, 0)); end
    run_to(base + (VA + VD - 1) * HT + HA + HD - 2);
    total++; if (pixel_xpos !== 10'(HD - 1)) begin bad++; $display("FAIL last_x: got %0d want %0d", pixel_xpos, HD - 1); end
    total++; if (pixel_ypos !== 10'(VD - 1)) begin bad++; $display("FAIL last_y: got %0d want %0d", pixel_ypos, VD - 1); end
    tick();
    total++; if (vga_rgb !== pix(HD - 1, VD - 1)) begin bad++; $display("FAIL last_pix: got %h want %h", vga_rgb, pix(HD - 1, VD - 1)); end
    total++; if (pixel_xpos !== 10'd0) begin bad++; $display("FAIL req_end: got %0d want 0", pixel_xpos); end
    tick();
    total++; if (vga_rgb !== 16'h0) begin bad++; $display("FAIL en_end: got %h want 0", vga_rgb); end
    run_to(base + (VA + VD) * HT);
    repeat (HT) begin
      total++; if (pixel_xpos !== 10'd0 || pixel_ypos !== 10'd0 || vga_rgb !== 16'h0)
        begin bad++; $display("FAIL post_line h=%0d: got x=%0d y=%0d rgb=%h want 0", mh(t), pixel_xpos, pixel_ypos, vga_rgb); end
      tick();
    end
  endtask

  task automatic test_datapath();
    salt = 16'($urandom);
    blank = 16'($urandom) | 16'h0001;
    repeat (FT) begin
      tick();
      total++; if (pixel_xpos !== 10'(m_x(t))) begin bad++; $display("FAIL d_xpos t=%0d: got %0d want %0d", t, pixel_xpos, m_x(t)); end
      total++; if (pixel_ypos !== 10'(m_y(t))) begin bad++; $display("FAIL d_ypos t=%0d: got %0d want %0d", t, pixel_ypos, m_y(t)); end
      total++; if (vga_rgb !== m_rgb(t)) begin bad++; $display("FAIL d_rgb t=%0d: got %h want %h", t, vga_rgb, m_rgb(t)); end
    end
    blank = 16'hFFFF;
  endtask

  task automatic test_midreset();
    int base, n, vs_low;
    base = ((t / FT) + 1) * FT;
    run_to(base + (VA + 2) * HT + HA + 3);
    total++; if (vga_rgb !== pix(3, 2)) begin bad++; $display("FAIL mid_pre_rgb: got %h want %h", vga_rgb, pix(3, 2)); end
    sys_rst_n = 1'b0;
    #1;
    total++; if (vga_hs !== 1'b0) begin bad++; $display("FAIL mid_hs: got %b want 0", vga_hs); end
    total++; if (vga_vs !== 1'b0) begin bad++; $display("FAIL mid_vs: got %b want 0", vga_vs); end
    total++; if (vga_rgb !== 16'h0) begin bad++; $display("FAIL mid_rgb: got %h want 0", vga_rgb); end
    total++; if (pixel_xpos !== 10'd0) begin bad++; $display("FAIL mid_xpos: got %0d want 0", pixel_xpos); end
    total++; if (pixel_ypos !== 10'd0) begin bad++; $display("FAIL mid_ypos: got %0d want 0", pixel_ypos); end
    total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL mid_fs: got %b want 0", frame_start); end
    running = 1'b0;
    t = 0;
    repeat (3) tick();
    sys_rst_n = 1'b1;
    running = 1'b1;
    #1;
    total++; if (vga_vs !== 1'b0) begin bad++; $display("FAIL mid_vs_restart: got %b want 0", vga_vs); end
    vs_low = (vga_vs === 1'b0) ? 1 : 0;
    n = 0;
    while (frame_start !== 1'b1 && n < FT + 50) begin
      tick();
      n++;
      if (frame_start !== 1'b1 && vga_vs === 1'b0) vs_low++;
    end
    total++; if (n != FT) begin bad++; $display("FAIL mid_fs_delay: got %0d want %0d", n, FT); end
    total++; if (vs_low != VS * HT) begin bad++; $display("FAIL mid_vs_low: got %0d want %0d", vs_low, VS * HT); end
  endtask

  initial begin
    test_reset();
    test_horizontal();
    test_frame();
    test_corners();
    test_datapath();
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
